// File: rtl/alu_pkg.sv
// Shared ALU constants: func codes, functional-unit bit indices and the
// index-to-func mapping used by both the decoder and the result encoder.
package alu_pkg;

  localparam int NUM_UNITS = 7;

  localparam logic [3:0] FUNC_ADD = 4'b0011;
  localparam logic [3:0] FUNC_SUB = 4'b0100;
  localparam logic [3:0] FUNC_XOR = 4'b0101;
  localparam logic [3:0] FUNC_OR  = 4'b0110;
  localparam logic [3:0] FUNC_AND = 4'b0111;
  localparam logic [3:0] FUNC_DIV = 4'b1000;
  localparam logic [3:0] FUNC_MOD = 4'b1001;

  localparam int IDX_XOR = 6;
  localparam int IDX_ADD = 5;
  localparam int IDX_SUB = 4;
  localparam int IDX_AND = 3;
  localparam int IDX_OR  = 2;
  localparam int IDX_DIV = 1;
  localparam int IDX_MOD = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic [3:0] idx_to_func(input logic [2:0] idx);
    logic [3:0] func;
    case (idx)
      3'(IDX_XOR): func = FUNC_XOR;
      3'(IDX_ADD): func = FUNC_ADD;
      3'(IDX_SUB): func = FUNC_SUB;
      3'(IDX_AND): func = FUNC_AND;
      3'(IDX_OR):  func = FUNC_OR;
      3'(IDX_DIV): func = FUNC_DIV;
      3'(IDX_MOD): func = FUNC_MOD;
      default:     func = 4'b0000;
    endcase
    return func;
  endfunction

endpackage

// File: rtl/alu_result_encoder_result_fifo2.sv
// Two-entry FIFO with a registered head; occupancy is tracked as a small FSM.
module result_fifo2
  import alu_pkg::*;
#(
  parameter int EW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [EW-1:0] din_i,
  output logic [EW-1:0] head_o,
  output logic          valid_o,
  output logic          full_o,
  output occ_e          occupancy_o
);

  occ_e          state_q, state_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // The head register is always the oldest entry, so a pop from FULL shifts tail up.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push_i) begin
          state_d = OCC_ONE;
          head_d  = din_i;
        end
      end
      OCC_ONE: begin
        if (push_i && pop_i) begin
          head_d = din_i;
        end else if (push_i) begin
          state_d = OCC_FULL;
          tail_d  = din_i;
        end else if (pop_i) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop_i) begin
          state_d = OCC_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_comb begin
    valid_o     = (state_q != OCC_EMPTY);
    full_o      = (state_q == OCC_FULL);
    occupancy_o = state_q;
    head_o      = head_q;
  end

endmodule

// File: rtl/alu_result_encoder.sv
// Collects functional-unit completions, re-encodes the winning unit to its
// func code and queues {func, result, collision} for the write-back stage.
module alu_result_encoder
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_UNITS-1:0]       unit_done,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
  output logic                       accept_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_func,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_collision,
  output logic                       overrun,
  input  logic                       clear_flags,
  output logic [7:0]                 collision_count
);

  localparam int EW = WIDTH + 5;

  logic [2:0]       winIdx;
  logic [WIDTH-1:0] winResult;
  logic             anyDone;
  logic             collision;
  logic             push;
  logic             pop;
  logic             fifoFull;
  logic [EW-1:0]    headEntry;
  occ_e             occupancy;

  logic             overrun_q, overrun_d;
  logic [7:0]       collCount_q, collCount_d;

  // Ascending scan so the highest set index is the last one to win.
  always_comb begin
    winIdx = 3'd0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_done[i]) winIdx = 3'(i);
    end
    winResult = unit_result[winIdx*WIDTH +: WIDTH];
    anyDone   = |unit_done;
    collision = (unit_done & (unit_done - 7'd1)) != 7'd0;
  end

  assign accept_ready = !fifoFull;
  assign push         = anyDone && accept_ready;
  assign pop          = out_valid && out_ready;

  result_fifo2 #(.EW(EW)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .din_i       ({idx_to_func(winIdx), winResult, collision}),
    .head_o      (headEntry),
    .valid_o     (out_valid),
    .full_o      (fifoFull),
    .occupancy_o (occupancy)
  );

  assign out_func      = headEntry[EW-1 -: 4];
  assign out_result    = headEntry[WIDTH:1];
  assign out_collision = headEntry[0];

  // A new event in the same cycle as clear_flags takes precedence over the clear.
  always_comb begin
    overrun_d   = clear_flags ? 1'b0 : overrun_q;
    collCount_d = clear_flags ? 8'd0 : collCount_q;
    if (anyDone && !accept_ready) overrun_d = 1'b1;
    if (push && collision && collCount_d != 8'hFF) collCount_d = collCount_d + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      collCount_q <= 8'd0;
    end else begin
      overrun_q   <= overrun_d;
      collCount_q <= collCount_d;
    end
  end

  assign overrun         = overrun_q;
  assign collision_count = collCount_q;

endmodule

// File: tb/tb_alu_result_encoder.sv
// Directed and randomized bench for alu_result_encoder against a queue-based
// model of the result buffer, flags and collision counter.
module tb_alu_result_encoder;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [3:0] func;
    logic [7:0] result;
    logic       coll;
  } entry_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [6:0]  unitDone;
  logic [55:0] unitResult;
  logic        acceptReady;
  logic        outValid;
  logic        outReady;
  logic [3:0]  outFunc;
  logic [7:0]  outResult;
  logic        outCollision;
  logic        overrun;
  logic        clearFlags;
  logic [7:0]  collisionCount;

  int total = 0;
  int bad   = 0;

  entry_t     mq[$];
  logic       mOver;
  int         mCount;
  logic       resetSeen;
  logic [3:0] funcTable [0:6];

  always #5 clk = ~clk;

  alu_result_encoder #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst_n           (rstN),
    .unit_done       (unitDone),
    .unit_result     (unitResult),
    .accept_ready    (acceptReady),
    .out_valid       (outValid),
    .out_ready       (outReady),
    .out_func        (outFunc),
    .out_result      (outResult),
    .out_collision   (outCollision),
    .overrun         (overrun),
    .clear_flags     (clearFlags),
    .collision_count (collisionCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelUpdate(input logic [6:0] done, input logic [55:0] res,
                             input logic ready, input logic clr, input logic rstn);
    int     sizeBefore;
    int     hi;
    entry_t e;
    if (!rstn) begin
      mq.delete();
      mOver     = 1'b0;
      mCount    = 0;
      resetSeen = 1'b1;
    end else begin
      sizeBefore = mq.size();
      if (clr) begin
        mOver  = 1'b0;
        mCount = 0;
      end
      if (done != 0 && sizeBefore >= 2) mOver = 1'b1;
      if (sizeBefore > 0 && ready) void'(mq.pop_front());
      if (done != 0 && sizeBefore < 2) begin
        hi = 0;
        for (int i = 6; i >= 0; i--) if (done[i] && hi == 0) hi = i + 1;
        e.func   = funcTable[hi-1];
        e.result = res[(hi-1)*8 +: 8];
        e.coll   = ($countones(done) > 1);
        if (e.coll && mCount < 255) mCount++;
        mq.push_back(e);
        resetSeen = 1'b0;
      end
    end
  endtask

  task automatic checkState();
    checkOutput("out_valid", 32'(outValid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      checkOutput("out_func", 32'(outFunc), 32'(mq[0].func));
      checkOutput("out_result", 32'(outResult), 32'(mq[0].result));
      checkOutput("out_collision", 32'(outCollision), 32'(mq[0].coll));
    end else if (resetSeen) begin
      checkOutput("reset_head", {outFunc, outResult, outCollision}, 32'd0);
    end
    checkOutput("overrun", 32'(overrun), 32'(mOver));
    checkOutput("collision_count", 32'(collisionCount), 32'(mCount));
  endtask

  // One clock: drive at negedge, check accept_ready, advance the model, check outputs.
  task automatic applyStimulus(input logic [6:0] done, input logic [55:0] res,
                               input logic ready, input logic clr, input logic rstn);
    unitDone   = done;
    unitResult = res;
    outReady   = ready;
    clearFlags = clr;
    rstN       = rstn;
    #1;
    checkOutput("accept_ready", 32'(acceptReady), 32'(mq.size() < 2));
    @(posedge clk);
    modelUpdate(done, res, ready, clr, rstn);
    @(negedge clk);
    checkState();
  endtask

  function automatic logic [55:0] slice(input int idx, input logic [7:0] val);
    logic [55:0] r;
    r = {$urandom, $urandom};
    r[idx*8 +: 8] = val;
    return r;
  endfunction

  initial begin
    logic [6:0]  rd;
    logic [55:0] rr;
    funcTable[0] = 4'b1001; funcTable[1] = 4'b1000; funcTable[2] = 4'b0110;
    funcTable[3] = 4'b0111; funcTable[4] = 4'b0100; funcTable[5] = 4'b0011;
    funcTable[6] = 4'b0101;
    mOver = 1'b0; mCount = 0; resetSeen = 1'b1;
    unitDone = '0; unitResult = '0; outReady = 1'b0; clearFlags = 1'b0; rstN = 1'b0;
    @(negedge clk);

    applyStimulus(7'd0, 56'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'd0, 56'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_accept", 32'(acceptReady), 32'd1);

    // Single add completion.
    applyStimulus(7'b0100000, slice(5, 8'h2A), 1'b0, 1'b0, 1'b1);
    checkOutput("add_func", 32'(outFunc), 32'h3);
    checkOutput("add_result", 32'(outResult), 32'h2A);
    applyStimulus(7'd0, 56'd0, 1'b1, 1'b0, 1'b1);

    // Fill with xor, div; mod dropped as overrun.
    applyStimulus(7'b1000000, slice(6, 8'h11), 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0000010, slice(1, 8'h22), 1'b0, 1'b0, 1'b1);
    checkOutput("full_accept", 32'(acceptReady), 32'd0);
    applyStimulus(7'b0000001, slice(0, 8'h33), 1'b0, 1'b0, 1'b1);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    checkOutput("head_xor", {outFunc, outResult}, 32'h511);
    applyStimulus(7'd0, 56'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("head_div", {outFunc, outResult}, 32'h822);
    applyStimulus(7'd0, 56'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("drained", 32'(outValid), 32'd0);

    // Collision: sub wins over div and mod.
    applyStimulus(7'b0010011, slice(4, 8'h55), 1'b0, 1'b0, 1'b1);
    checkOutput("coll_entry", {outFunc, outResult, outCollision}, 32'h8AB);
    checkOutput("coll_count1", 32'(collisionCount), 32'd1);
    applyStimulus(7'd0, 56'd0, 1'b1, 1'b1, 1'b1);

    // Streaming at occupancy ONE.
    applyStimulus(7'b0000100, slice(2, 8'h0F), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(7'b0000100, slice(2, 8'h0F), 1'b1, 1'b0, 1'b1);
    checkOutput("stream_one", 32'(acceptReady), 32'd1);
    applyStimulus(7'd0, 56'd0, 1'b1, 1'b0, 1'b1);

    // Saturating collision counter, then clear.
    for (int i = 0; i < 256; i++) applyStimulus(7'b0000011, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
    checkOutput("coll_sat", 32'(collisionCount), 32'd255);
    applyStimulus(7'd0, 56'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("coll_clear", 32'(collisionCount), 32'd0);

    // Reset while FULL with overrun set and a strobe in the reset cycle.
    applyStimulus(7'b0001000, slice(3, 8'hA1), 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0001000, slice(3, 8'hA2), 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0001000, slice(3, 8'hA3), 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0110000, 56'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_flags", {overrun, collisionCount}, 32'd0);
    applyStimulus(7'b0000100, slice(2, 8'h77), 1'b0, 1'b0, 1'b1);
    checkOutput("post_rst", {outFunc, outResult}, 32'h677);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rd = 7'd0;
        4, 5, 6, 7: rd = 7'(1 << $urandom_range(0, 6));
        default:    rd = 7'($urandom);
      endcase
      rr = {$urandom, $urandom};
      applyStimulus(rd, rr, 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 80) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
